// File: rtl/chan_scan_mux.sv
// chan_scan_mux: N-channel, W-bit multiplexer with a registered output and a
// valid/ready handshake towards a single consumer.
//
// Modes (mode is only looked at while IDLE):
//   mode=0  direct: every cycle the output slot is free, channel 'sel' is
//           captured. An out-of-range sel gives y=0 with sel_err=1.
//   mode=1  scan:   a 'start' pulse sweeps channels 0..N-1 once. Each channel
//           settles for DWELL cycles before it is captured, and done pulses
//           with the last sample.
//
// Optional build macro SCAN_MASK_EN adds input ch_en[N-1:0]. A disabled
// channel is skipped in scan, taking one cycle and producing no capture. In
// direct mode a disabled channel is treated like an out-of-range sel.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i[N*W-1:0]      packed channel data, channel k = i[k*W +: W]
//   sel[SW-1:0]     direct-mode channel select
//   mode, start     mode select / sweep start
//   ch_en[N-1:0]    channel enable mask (SCAN_MASK_EN only)
//   y_ready         consumer accepts y this cycle
//   y, y_valid      registered sample and its valid flag
//   y_chan          channel index of y
//   sel_err         current direct sample used an invalid sel
//   busy            sweep in progress
//   done            one-cycle pulse alongside the final sweep sample
module chan_scan_mux #(
    parameter int N     = 16,
    parameter int W     = 1,
    parameter int DWELL = 1,
    parameter int SW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  i,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    input  logic            start,
`ifdef SCAN_MASK_EN
    input  logic [N-1:0]    ch_en,
`endif
    input  logic            y_ready,
    output logic [W-1:0]    y,
    output logic            y_valid,
    output logic [SW-1:0]   y_chan,
    output logic            sel_err,
    output logic            busy,
    output logic            done
);

    localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SW-1:0]   LAST_CH    = SW'(N - 1);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SW:0]     N_EXT      = (SW + 1)'(N);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Channel lookup by loop so that an out-of-range index never forms an
    // out-of-range part-select; unmatched indices return zero.
    function automatic logic [W-1:0] pick_chan(input logic [N*W-1:0] d,
                                               input logic [SW-1:0]  idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == k[SW-1:0]) begin
                r = d[k*W +: W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic chan_on(input logic [N-1:0]  en,
                                     input logic [SW-1:0] idx);
        logic r;
        r = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (idx == k[SW-1:0]) begin
                r = en[k];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [N-1:0]  ch_en_s;
`ifdef SCAN_MASK_EN
    assign ch_en_s = ch_en;
`else
    assign ch_en_s = {N{1'b1}};
`endif

    state_t        state_r, state_s;
    logic [SW-1:0] ch_r, ch_s;
    logic [DW-1:0] dwell_r, dwell_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic [W-1:0]  y_r;
    logic          y_valid_r;
    logic [SW-1:0] y_chan_r;
    logic          sel_err_r;

    logic          slot_free_s;
    logic          capture_s;
    logic [W-1:0]  cap_data_s;
    logic [SW-1:0] cap_chan_s;
    logic          cap_err_s;
    logic          sel_ok_s;

    assign slot_free_s = !y_valid_r || y_ready;
    assign sel_ok_s    = ({1'b0, sel} < N_EXT) && chan_on(ch_en_s, sel);

    // Next-state, sweep bookkeeping and capture decision.
    always_comb begin
        state_s    = state_r;
        ch_s       = ch_r;
        dwell_s    = dwell_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        capture_s  = 1'b0;
        cap_data_s = '0;
        cap_chan_s = '0;
        cap_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!mode) begin
                    if (slot_free_s) begin
                        capture_s  = 1'b1;
                        cap_chan_s = sel;
                        if (sel_ok_s) begin
                            cap_data_s = pick_chan(i, sel);
                            cap_err_s  = 1'b0;
                        end else begin
                            cap_data_s = '0;
                            cap_err_s  = 1'b1;
                        end
                    end else begin
                        capture_s = 1'b0;
                    end
                end else if (start) begin
                    state_s = ST_SCAN;
                    ch_s    = '0;
                    dwell_s = '0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!chan_on(ch_en_s, ch_r)) begin
                    // Disabled channel: one cycle, no dwell, no capture.
                    dwell_s = '0;
                    if (ch_r == LAST_CH) begin
                        ch_s    = '0;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        ch_s = ch_r + SW'(1);
                    end
                end else if (dwell_r == DWELL_LAST) begin
                    if (slot_free_s) begin
                        capture_s  = 1'b1;
                        cap_data_s = pick_chan(i, ch_r);
                        cap_chan_s = ch_r;
                        cap_err_s  = 1'b0;
                        dwell_s    = '0;
                        if (ch_r == LAST_CH) begin
                            ch_s    = '0;
                            done_s  = 1'b1;
                            busy_s  = 1'b0;
                            state_s = ST_IDLE;
                        end else begin
                            ch_s = ch_r + SW'(1);
                        end
                    end else begin
                        // Stall: settled channel waits for the output slot.
                        ch_s    = ch_r;
                        dwell_s = dwell_r;
                    end
                end else begin
                    dwell_s = dwell_r + DW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                ch_s    = '0;
                dwell_s = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // FSM and sweep counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ch_r    <= '0;
            dwell_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ch_r    <= ch_s;
            dwell_r <= dwell_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Single-sample output register with valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r       <= '0;
            y_valid_r <= 1'b0;
            y_chan_r  <= '0;
            sel_err_r <= 1'b0;
        end else if (capture_s) begin
            y_r       <= cap_data_s;
            y_chan_r  <= cap_chan_s;
            sel_err_r <= cap_err_s;
            y_valid_r <= 1'b1;
        end else if (y_ready) begin
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= y_valid_r;
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;
    assign y_chan  = y_chan_r;
    assign sel_err = sel_err_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed self-checking bench for chan_scan_mux: a default instance
// (N=16, DWELL=1), a DWELL=3 instance and an N=12 instance share one clock
// and reset. With SCAN_MASK_EN defined the default instance also gets a
// channel-mask sweep.
module tb_chan_scan_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: N=16, W=1, DWELL=1
    logic [15:0] a_i = 16'h0000;
    logic [3:0]  a_sel = 4'd0;
    logic        a_mode = 1'b0, a_start = 1'b0, a_ready = 1'b1;
    logic        a_y, a_valid, a_err, a_busy, a_done;
    logic [3:0]  a_chan;
`ifdef SCAN_MASK_EN
    logic [15:0] a_en = 16'hFFFF;
    logic [15:0] b_en = 16'hFFFF;
    logic [11:0] c_en = 12'hFFF;
`endif

    chan_scan_mux #(.N(16), .W(1), .DWELL(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i(a_i), .sel(a_sel), .mode(a_mode),
        .start(a_start),
`ifdef SCAN_MASK_EN
        .ch_en(a_en),
`endif
        .y_ready(a_ready), .y(a_y), .y_valid(a_valid), .y_chan(a_chan),
        .sel_err(a_err), .busy(a_busy), .done(a_done));

    // Instance B: N=16, W=1, DWELL=3
    logic [15:0] b_i = 16'h0001;
    logic [3:0]  b_sel = 4'd0;
    logic        b_mode = 1'b1, b_start = 1'b0, b_ready = 1'b1;
    logic        b_y, b_valid, b_err, b_busy, b_done;
    logic [3:0]  b_chan;

    chan_scan_mux #(.N(16), .W(1), .DWELL(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .i(b_i), .sel(b_sel), .mode(b_mode),
        .start(b_start),
`ifdef SCAN_MASK_EN
        .ch_en(b_en),
`endif
        .y_ready(b_ready), .y(b_y), .y_valid(b_valid), .y_chan(b_chan),
        .sel_err(b_err), .busy(b_busy), .done(b_done));

    // Instance C: N=12, W=1, DWELL=1
    logic [11:0] c_i = 12'h800;
    logic [3:0]  c_sel = 4'd0;
    logic        c_mode = 1'b0, c_start = 1'b0, c_ready = 1'b1;
    logic        c_y, c_valid, c_err, c_busy, c_done;
    logic [3:0]  c_chan;

    chan_scan_mux #(.N(12), .W(1), .DWELL(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .i(c_i), .sel(c_sel), .mode(c_mode),
        .start(c_start),
`ifdef SCAN_MASK_EN
        .ch_en(c_en),
`endif
        .y_ready(c_ready), .y(c_y), .y_valid(c_valid), .y_chan(c_chan),
        .sel_err(c_err), .busy(c_busy), .done(c_done));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic ey, input logic [3:0] ech,
                         input logic ev, input logic ebusy, input logic edone);
        chk({tag, ".y"}, {31'd0, a_y}, {31'd0, ey});
        chk({tag, ".chan"}, {28'd0, a_chan}, {28'd0, ech});
        chk({tag, ".valid"}, {31'd0, a_valid}, {31'd0, ev});
        chk({tag, ".busy"}, {31'd0, a_busy}, {31'd0, ebusy});
        chk({tag, ".done"}, {31'd0, a_done}, {31'd0, edone});
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'hF0F0;

        // Reset state
        #2;
        chk_a("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("reset.err", {31'd0, a_err}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Direct mode, i=AAAA
        a_i = 16'hAAAA; a_mode = 1'b0; a_ready = 1'b1;
        a_sel = 4'd0; tick(); chk_a("dir0", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        a_sel = 4'd1; tick(); chk_a("dir1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        a_sel = 4'd4; tick(); chk_a("dir4", 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
        chk("dir4.err", {31'd0, a_err}, 32'd0);

        // Scan sweep, i=F0F0, DWELL=1
        a_i = pat; a_mode = 1'b1; a_start = 1'b1;
        tick(); a_start = 1'b0;
        chk("scan.busy_start", {31'd0, a_busy}, 32'd1);
        chk("scan.valid_start", {31'd0, a_valid}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_a($sformatf("scan%0d", k), pat[k], 4'(k), 1'b1, (k != 15), (k == 15));
        end
        tick();
        chk_a("scan.after", pat[15], 4'd15, 1'b0, 1'b0, 1'b0);

        // Backpressure after first sample
        a_start = 1'b1; tick(); a_start = 1'b0;
        tick(); chk_a("bp.first", pat[0], 4'd0, 1'b1, 1'b1, 1'b0);
        a_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(); chk_a($sformatf("bp.hold%0d", k), pat[0], 4'd0, 1'b1, 1'b1, 1'b0);
        end
        a_ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            tick();
            chk_a($sformatf("bp.resume%0d", k), pat[k], 4'(k), 1'b1, (k != 15), (k == 15));
        end
        tick();

        // Reset in the middle of a sweep at chan 7
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk_a("mid.before", pat[7], 4'd7, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_a("mid.async", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("mid.held", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        a_start = 1'b1; tick(); a_start = 1'b0;
        tick(); chk_a("mid.restart", pat[0], 4'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 16; k++) tick();
        chk_a("mid.end", pat[15], 4'd15, 1'b1, 1'b0, 1'b1);
        tick();

        // DWELL=3 sweep on instance B, i=0001
        b_mode = 1'b1; b_start = 1'b1; tick(); b_start = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            tick();
            chk($sformatf("d3.valid%0d", c), {31'd0, b_valid}, {31'd0, (c % 3 == 0)});
            chk($sformatf("d3.done%0d", c), {31'd0, b_done}, {31'd0, (c == 48)});
            if (c % 3 == 0) begin
                chk($sformatf("d3.chan%0d", c), {28'd0, b_chan}, 32'(c / 3 - 1));
                chk($sformatf("d3.y%0d", c), {31'd0, b_y}, {31'd0, (c == 3)});
            end
        end
        tick();
        chk("d3.busy_end", {31'd0, b_busy}, 32'd0);

        // N=12 direct select boundaries, i[11]=1
        c_sel = 4'd13; tick();
        chk("n12.s13.y", {31'd0, c_y}, 32'd0);
        chk("n12.s13.err", {31'd0, c_err}, 32'd1);
        chk("n12.s13.chan", {28'd0, c_chan}, 32'd13);
        c_sel = 4'd11; tick();
        chk("n12.s11.y", {31'd0, c_y}, 32'd1);
        chk("n12.s11.err", {31'd0, c_err}, 32'd0);
        c_sel = 4'd12; tick();
        chk("n12.s12.err", {31'd0, c_err}, 32'd1);
        chk("n12.s12.y", {31'd0, c_y}, 32'd0);
        c_sel = 4'd10; tick();
        chk("n12.s10.y", {31'd0, c_y}, 32'd0);
        chk("n12.s10.err", {31'd0, c_err}, 32'd0);

`ifdef SCAN_MASK_EN
        // Masked sweep: only channels 0..7 sampled, done after 16 cycles
        a_en = 16'h00FF; a_ready = 1'b1;
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_a($sformatf("mask%0d", k), pat[k], 4'(k), 1'b1, 1'b1, 1'b0);
        end
        a_ready = 1'b0;
        for (int k = 8; k < 16; k++) begin
            tick();
            chk_a($sformatf("mask.skip%0d", k), pat[7], 4'd7, 1'b1, (k != 15), (k == 15));
        end
        a_ready = 1'b1;
        a_en = 16'hFFFF;
        // Direct select of a disabled channel
        c_en = 12'h7FF; c_sel = 4'd11; tick();
        chk("mask.dir.err", {31'd0, c_err}, 32'd1);
        chk("mask.dir.y", {31'd0, c_y}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
